// File: rtl/que_pkg.sv
// Shared types and constants for the nibble queue blocks.
package que_pkg;

    localparam int QUE_NIB_W = 4;
    localparam int QUE_LANES = 4;
    localparam int QUE_CNT_W = $clog2(QUE_LANES) + 1;

    typedef logic [QUE_NIB_W-1:0] que_nib_t;

    typedef enum logic {
        PACK_FILL,
        PACK_HOLD
    } que_pack_state_e;

endpackage

// File: rtl/que_nibble_packer.sv
// Packs LANES nibbles (oldest in the LSB lane) into one word with a lane count; flush closes a partial word.
// Optional QUE_PACK_PARITY_EN adds out_par, the XOR of out_data, registered with it.
module que_nibble_packer
    import que_pkg::*;
#(
    parameter int NIB_W = QUE_NIB_W,
    parameter int LANES = QUE_LANES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NIB_W-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [LANES*NIB_W-1:0]     out_data,
    output logic [$clog2(LANES):0]     out_count,
    output logic                       out_valid,
`ifdef QUE_PACK_PARITY_EN
    output logic                       out_par,
`endif
    input  logic                       out_ready
);

    localparam int CNT_W = $clog2(LANES) + 1;

    que_pack_state_e          state, state_nxt;
    logic [CNT_W-1:0]         fill, fill_nxt, fill_inc;
    logic [CNT_W-1:0]         cnt_q, cnt_nxt;
    logic [LANES*NIB_W-1:0]   data_q, data_nxt;
    logic                     accept, drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill;
        cnt_nxt   = cnt_q;
        data_nxt  = data_q;
        fill_inc  = fill + CNT_W'(accept);
        case (state)
            PACK_FILL: begin
                if (accept) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (fill == CNT_W'(i)) data_nxt[i*NIB_W +: NIB_W] = in_data;
                    end
                end
                fill_nxt = fill_inc;
                // A flush only closes a word that would hold at least one entry.
                if (fill_inc == CNT_W'(LANES) || (flush && fill_inc != '0)) begin
                    state_nxt = PACK_HOLD;
                    cnt_nxt   = fill_inc;
                end
            end
            PACK_HOLD: begin
                if (drain) begin
                    state_nxt = PACK_FILL;
                    fill_nxt  = '0;
                    cnt_nxt   = '0;
                    data_nxt  = '0;
                end
            end
            default: state_nxt = PACK_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PACK_FILL;
            fill      <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            fill      <= fill_nxt;
            cnt_q     <= cnt_nxt;
            data_q    <= data_nxt;
            // Handshake flags are registered copies of the next state.
            in_ready  <= (state_nxt == PACK_FILL);
            out_valid <= (state_nxt == PACK_HOLD);
        end
    end

`ifdef QUE_PACK_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_par <= 1'b0;
        else        out_par <= ^data_nxt;
    end
`endif

    assign out_data  = data_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_que_nibble_packer.sv
// Randomised and directed bench for que_nibble_packer against a queue-based packing model.
module tb_que_nibble_packer;
    import que_pkg::*;

    localparam int NW = QUE_NIB_W;
    localparam int LN = QUE_LANES;
    localparam int WW = NW * LN;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            flush = 1'b0;
    logic [WW-1:0]   out_data;
    logic [QUE_CNT_W-1:0] out_count;
    logic            out_valid;
    logic            out_ready = 1'b0;
`ifdef QUE_PACK_PARITY_EN
    logic            out_par;
`endif

    que_nibble_packer dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data),
        .out_count(out_count), .out_valid(out_valid),
`ifdef QUE_PACK_PARITY_EN
        .out_par(out_par),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: pending entries in a queue, one closed word at a time.
    int unsigned   m_q[$];
    bit            m_rdy, m_vld;
    logic [WW-1:0] m_word;
    int            m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_rdy = 0; m_vld = 0; m_word = '0; m_cnt = 0;
        end else if (m_vld) begin
            if (out_ready) begin m_vld = 0; m_rdy = 1; end
        end else if (m_rdy) begin
            if (in_valid) m_q.push_back(int'(in_data));
            if (m_q.size() == LN || (flush && m_q.size() > 0)) begin
                m_word = '0;
                foreach (m_q[i]) m_word = m_word | (WW'(m_q[i]) << (i * NW));
                m_cnt = m_q.size();
                m_q.delete();
                m_vld = 1; m_rdy = 0;
            end
        end else begin
            m_rdy = 1;
        end
    end

    // Compare process plus capture of the most recent DUT word.
    logic [WW-1:0] cap_data;
    int            cap_cnt;
    logic          cap_par;
    int            rdy_low;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(m_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_vld));
            if (!in_ready) rdy_low++;
            if (m_vld) begin
                chk("out_data", 32'(out_data), 32'(m_word));
                chk("out_count", 32'(out_count), 32'(m_cnt));
`ifdef QUE_PACK_PARITY_EN
                chk("out_par", 32'(out_par), 32'(^m_word));
                cap_par = out_par;
`endif
                cap_data = out_data;
                cap_cnt  = int'(out_count);
            end
        end
    end

    task automatic drive(input bit v, input int d, input bit f, input bit r);
        @(posedge clk); #1;
        in_valid = v; in_data = NW'(d); flush = f; out_ready = r;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) drive(0, 0, 0, r);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_rst_data"}, 32'(out_data), 0);
        chk({tag, "_rst_cnt"}, 32'(out_count), 0);
        chk({tag, "_rst_vld"}, 32'(out_valid), 0);
        chk({tag, "_rst_rdy"}, 32'(in_ready), 0);
`ifdef QUE_PACK_PARITY_EN
        chk({tag, "_rst_par"}, 32'(out_par), 0);
`endif
    endtask

    initial begin
        #2 reset_check("init");
        #21 rst_n = 1'b1;
        idle(1, 1);

        // Full word
        rdy_low = 0;
        drive(1, 6, 0, 1); drive(1, 9, 0, 1); drive(1, 8, 0, 1); drive(1, 11, 0, 1);
        idle(3, 1);
        chk("full_data", 32'(cap_data), 32'h0000B896);
        chk("full_cnt", 32'(cap_cnt), 4);
        chk("full_rdy_low", 32'(rdy_low), 1);

        // Flush partial
        drive(1, 2, 0, 1); drive(1, 3, 0, 1); drive(0, 0, 1, 1);
        idle(3, 1);
        chk("flush_data", 32'(cap_data), 32'h00000032);
        chk("flush_cnt", 32'(cap_cnt), 2);
`ifdef QUE_PACK_PARITY_EN
        chk("flush_par", 32'(cap_par), 1);
`endif

        // Flush with accept
        drive(1, 12, 1, 1);
        idle(3, 1);
        chk("flacc_data", 32'(cap_data), 32'h0000000C);
        chk("flacc_cnt", 32'(cap_cnt), 1);

        // Flush on empty
        drive(0, 0, 1, 1);
        idle(2, 1);
        chk("flempty_vld", 32'(out_valid), 0);
        chk("flempty_rdy", 32'(in_ready), 1);

        // Backpressure
        drive(1, 1, 0, 0); drive(1, 2, 0, 0); drive(1, 3, 0, 0); drive(1, 4, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 15, 0, 0);
            #3 chk("bp_hold", 32'(out_data), 32'h00004321);
        end
        drive(0, 0, 0, 1);
        idle(2, 1);
        chk("bp_data", 32'(cap_data), 32'h00004321);

        // Reset mid-fill
        drive(1, 5, 0, 1); drive(1, 7, 0, 1);
        drive(0, 0, 0, 1);
        #1 rst_n = 1'b0;
        #1 reset_check("mid");
        #2 rst_n = 1'b1;
        idle(1, 1);
        drive(1, 1, 0, 1); drive(1, 1, 0, 1); drive(1, 1, 0, 1); drive(1, 1, 0, 1);
        idle(3, 1);
        chk("rst_data", 32'(cap_data), 32'h00001111);
        chk("rst_cnt", 32'(cap_cnt), 4);
`ifdef QUE_PACK_PARITY_EN
        chk("rst_par", 32'(cap_par), 0);
`endif

        // Random traffic, model-checked every cycle
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
            if (i == 300) begin
                #2 rst_n = 1'b0;
                #1 reset_check("rnd");
                #1 rst_n = 1'b1;
            end
        end
        idle(4, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
